// File: rtl/pattern_pkg.sv
// Shared constants for the test-pattern generator.
//   - PSEL encodings for the eight patterns
//   - colour constants and the colour-bar table
//   - per-RESOL lookup of active width (HDO), active height (VDO) and bar width (BW).
//     The values match the display sync generator's resolution table.
package pattern_pkg;

  // Pattern select encodings
  localparam logic [2:0] PselBars   = 3'd0;
  localparam logic [2:0] PselRamp   = 3'd1;
  localparam logic [2:0] PselCheck  = 3'd2;
  localparam logic [2:0] PselScroll = 3'd3;
  localparam logic [2:0] PselRed    = 3'd4;
  localparam logic [2:0] PselGreen  = 3'd5;
  localparam logic [2:0] PselBlue   = 3'd6;
  localparam logic [2:0] PselBorder = 3'd7;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t ColBlack   = '{r: 8'h00, g: 8'h00, b: 8'h00};
  localparam rgb_t ColWhite   = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
  localparam rgb_t ColYellow  = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
  localparam rgb_t ColCyan    = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
  localparam rgb_t ColGreen   = '{r: 8'h00, g: 8'hFF, b: 8'h00};
  localparam rgb_t ColMagenta = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
  localparam rgb_t ColRed     = '{r: 8'hFF, g: 8'h00, b: 8'h00};
  localparam rgb_t ColBlue    = '{r: 8'h00, g: 8'h00, b: 8'hFF};

  // Colour-bar order, left to right
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = ColWhite;
      3'd1:    c = ColYellow;
      3'd2:    c = ColCyan;
      3'd3:    c = ColGreen;
      3'd4:    c = ColMagenta;
      3'd5:    c = ColRed;
      3'd6:    c = ColBlue;
      default: c = ColBlack;
    endcase
    return c;
  endfunction

  // Active pixels per line
  function automatic int unsigned res_hdo(input logic [1:0] resol);
    int unsigned v;
    case (resol)
      2'd0:    v = 640;
      2'd1:    v = 800;
      2'd2:    v = 1024;
      default: v = 1280;
    endcase
    return v;
  endfunction

  // Active lines per frame
  function automatic int unsigned res_vdo(input logic [1:0] resol);
    int unsigned v;
    case (resol)
      2'd0:    v = 480;
      2'd1:    v = 600;
      2'd2:    v = 768;
      default: v = 1024;
    endcase
    return v;
  endfunction

  // Colour-bar width: one eighth of the active width
  function automatic int unsigned res_bw(input logic [1:0] resol);
    int unsigned v;
    case (resol)
      2'd0:    v = 80;
      2'd1:    v = 100;
      2'd2:    v = 128;
      default: v = 160;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/patgen_coord.sv
// Raster position tracker for the pattern generator.
// Detects frame start (VSYNC falling edge) and line end (preDE falling edge) and keeps:
//   xcnt_o   - index of the pixel being produced on the next cycle (0 outside preDE)
//   ycnt_o   - line within the frame, cleared at frame start
//   fcnt_o   - frame counter, wraps
//   baridx_o - colour-bar index along the line
//   psel_o / resol_o - pattern and resolution latched at frame start
// Ports: DCLK, DRST_X (sync, active-low), resol_i, psel_i, vsync_x_i, prede_i in; the above out.
module patgen_coord
  import pattern_pkg::*;
#(
  parameter int unsigned CW = 11,
  parameter int unsigned FW = 8
) (
  input  logic          DCLK,
  input  logic          DRST_X,
  input  logic [1:0]    resol_i,
  input  logic [2:0]    psel_i,
  input  logic          vsync_x_i,
  input  logic          prede_i,
  output logic [CW-1:0] xcnt_o,
  output logic [CW-1:0] ycnt_o,
  output logic [FW-1:0] fcnt_o,
  output logic [2:0]    baridx_o,
  output logic [2:0]    psel_o,
  output logic [1:0]    resol_o
);

  logic          vsync_x_q, vsync_x_d;
  logic          prede_q, prede_d;
  logic [CW-1:0] xcnt_q, xcnt_d;
  logic [CW-1:0] ycnt_q, ycnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [7:0]    barcnt_q, barcnt_d;
  logic [2:0]    baridx_q, baridx_d;
  logic [2:0]    psel_q, psel_d;
  logic [1:0]    resol_q, resol_d;

  logic frame_start;
  logic line_end;
  logic bar_last;

  assign frame_start = vsync_x_q & ~vsync_x_i;
  assign line_end    = prede_q & ~prede_i;
  assign bar_last    = (barcnt_q == 8'(res_bw(resol_q) - 1));

  always_comb begin
    vsync_x_d = vsync_x_i;
    prede_d   = prede_i;
    xcnt_d    = prede_i ? xcnt_q + 1'b1 : '0;
    ycnt_d    = ycnt_q;
    fcnt_d    = fcnt_q;
    psel_d    = psel_q;
    resol_d   = resol_q;
    barcnt_d  = '0;
    baridx_d  = '0;

    // Frame start takes priority over a coincident line end
    if (frame_start) begin
      ycnt_d  = '0;
      fcnt_d  = fcnt_q + 1'b1;
      psel_d  = psel_i;
      resol_d = resol_i;
    end else if (line_end) begin
      ycnt_d = ycnt_q + 1'b1;
    end

    if (prede_i) begin
      if (bar_last) begin
        barcnt_d = '0;
        baridx_d = baridx_q + 1'b1;
      end else begin
        barcnt_d = barcnt_q + 1'b1;
        baridx_d = baridx_q;
      end
    end
  end

  always_ff @(posedge DCLK) begin
    if (!DRST_X) begin
      vsync_x_q <= 1'b1;
      prede_q   <= 1'b0;
      xcnt_q    <= '0;
      ycnt_q    <= '0;
      fcnt_q    <= '0;
      barcnt_q  <= '0;
      baridx_q  <= '0;
      psel_q    <= '0;
      resol_q   <= '0;
    end else begin
      vsync_x_q <= vsync_x_d;
      prede_q   <= prede_d;
      xcnt_q    <= xcnt_d;
      ycnt_q    <= ycnt_d;
      fcnt_q    <= fcnt_d;
      barcnt_q  <= barcnt_d;
      baridx_q  <= baridx_d;
      psel_q    <= psel_d;
      resol_q   <= resol_d;
    end
  end

  assign xcnt_o   = xcnt_q;
  assign ycnt_o   = ycnt_q;
  assign fcnt_o   = fcnt_q;
  assign baridx_o = baridx_q;
  assign psel_o   = psel_q;
  assign resol_o  = resol_q;

endmodule

// File: rtl/patgen.sv
// Test-pattern generator driven by the display sync generator's timing.
// Syncs and DE are delayed one cycle; RGB is registered in the same stage so all leave together.
// Ports:
//   DCLK, DRST_X (sync, active-low)       - clock and reset
//   RESOL, PSEL                           - resolution / pattern select, latched at frame start
//   HSYNC_X_I, VSYNC_X_I, PREDE_I         - timing from the sync generator
//   DSP_HSYNC_X, DSP_VSYNC_X, DSP_DE      - timing delayed by one cycle
//   DSP_R, DSP_G, DSP_B                   - pixel colour, zero outside DE
module patgen
  import pattern_pkg::*;
#(
  parameter int unsigned CW = 11,
  parameter int unsigned FW = 8
) (
  input  logic       DCLK,
  input  logic       DRST_X,
  input  logic [1:0] RESOL,
  input  logic [2:0] PSEL,
  input  logic       HSYNC_X_I,
  input  logic       VSYNC_X_I,
  input  logic       PREDE_I,
  output logic       DSP_HSYNC_X,
  output logic       DSP_VSYNC_X,
  output logic       DSP_DE,
  output logic [7:0] DSP_R,
  output logic [7:0] DSP_G,
  output logic [7:0] DSP_B
);

  logic [CW-1:0] xcnt;
  logic [CW-1:0] ycnt;
  logic [FW-1:0] fcnt;
  logic [2:0]    baridx;
  logic [2:0]    psel_lat;
  logic [1:0]    resol_lat;

  patgen_coord #(
    .CW (CW),
    .FW (FW)
  ) u_coord (
    .DCLK      (DCLK),
    .DRST_X    (DRST_X),
    .resol_i   (RESOL),
    .psel_i    (PSEL),
    .vsync_x_i (VSYNC_X_I),
    .prede_i   (PREDE_I),
    .xcnt_o    (xcnt),
    .ycnt_o    (ycnt),
    .fcnt_o    (fcnt),
    .baridx_o  (baridx),
    .psel_o    (psel_lat),
    .resol_o   (resol_lat)
  );

  rgb_t          pix;
  logic [CW-1:0] scroll_x;
  logic          border;

  always_comb begin
    // Scrolling checker shifts by one pixel per frame; the add wraps at CW bits
    scroll_x = xcnt + CW'(fcnt);
    border   = (xcnt == '0) || (xcnt == CW'(res_hdo(resol_lat) - 1)) ||
               (ycnt == '0) || (ycnt == CW'(res_vdo(resol_lat) - 1));
    pix      = ColBlack;
    case (psel_lat)
      PselBars:   pix = bar_colour(baridx);
      PselRamp:   pix = '{r: xcnt[7:0], g: xcnt[7:0], b: xcnt[7:0]};
      PselCheck:  pix = (xcnt[5] ^ ycnt[5]) ? ColWhite : ColBlack;
      PselScroll: pix = (scroll_x[5] ^ ycnt[5]) ? ColWhite : ColBlack;
      PselRed:    pix = ColRed;
      PselGreen:  pix = ColGreen;
      PselBlue:   pix = ColBlue;
      PselBorder: pix = border ? ColWhite : ColBlack;
      default:    pix = ColBlack;
    endcase
  end

  logic hsync_x_q, vsync_x_q, de_q;
  rgb_t rgb_q;

  always_ff @(posedge DCLK) begin
    if (!DRST_X) begin
      hsync_x_q <= 1'b1;
      vsync_x_q <= 1'b1;
      de_q      <= 1'b0;
      rgb_q     <= ColBlack;
    end else begin
      hsync_x_q <= HSYNC_X_I;
      vsync_x_q <= VSYNC_X_I;
      de_q      <= PREDE_I;
      rgb_q     <= PREDE_I ? pix : ColBlack;
    end
  end

  assign DSP_HSYNC_X = hsync_x_q;
  assign DSP_VSYNC_X = vsync_x_q;
  assign DSP_DE      = de_q;
  assign DSP_R       = rgb_q.r;
  assign DSP_G       = rgb_q.g;
  assign DSP_B       = rgb_q.b;

endmodule

// File: tb/tb_patgen.sv
// Bench for patgen: a small sync generator produces frames of configurable size, a reference
// model derives each pixel from its raster position, and a monitor checks every output cycle.
module tb_patgen;

  logic       DCLK;
  logic       DRST_X;
  logic [1:0] RESOL;
  logic [2:0] PSEL;
  logic       HSYNC_X_I, VSYNC_X_I, PREDE_I;
  logic       DSP_HSYNC_X, DSP_VSYNC_X, DSP_DE;
  logic [7:0] DSP_R, DSP_G, DSP_B;

  patgen dut (
    .DCLK        (DCLK),
    .DRST_X      (DRST_X),
    .RESOL       (RESOL),
    .PSEL        (PSEL),
    .HSYNC_X_I   (HSYNC_X_I),
    .VSYNC_X_I   (VSYNC_X_I),
    .PREDE_I     (PREDE_I),
    .DSP_HSYNC_X (DSP_HSYNC_X),
    .DSP_VSYNC_X (DSP_VSYNC_X),
    .DSP_DE      (DSP_DE),
    .DSP_R       (DSP_R),
    .DSP_G       (DSP_G),
    .DSP_B       (DSP_B)
  );

  initial begin
    DCLK = 1'b0;
    forever #5 DCLK = ~DCLK;
  end

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state, kept in frame/line terms
  int frame_no  = 0;
  int lat_psel  = 0;
  int lat_resol = 0;

  function automatic logic [23:0] model_pix(input int psel, input int resol, input int x,
                                            input int y, input int f);
    int          bw, hdo, vdo;
    logic [7:0]  g;
    logic [23:0] res;
    case (resol)
      0:       begin bw = 80;  hdo = 640;  vdo = 480;  end
      1:       begin bw = 100; hdo = 800;  vdo = 600;  end
      2:       begin bw = 128; hdo = 1024; vdo = 768;  end
      default: begin bw = 160; hdo = 1280; vdo = 1024; end
    endcase
    res = 24'h000000;
    case (psel)
      0: begin
        case ((x / bw) % 8)
          0:       res = 24'hFFFFFF;
          1:       res = 24'hFFFF00;
          2:       res = 24'h00FFFF;
          3:       res = 24'h00FF00;
          4:       res = 24'hFF00FF;
          5:       res = 24'hFF0000;
          6:       res = 24'h0000FF;
          default: res = 24'h000000;
        endcase
      end
      1: begin
        g   = 8'(x % 256);
        res = {g, g, g};
      end
      2: res = (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      3: res = (((((x + f) % 2048) / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      4: res = 24'hFF0000;
      5: res = 24'h00FF00;
      6: res = 24'h0000FF;
      default:
        res = (x == 0 || x == hdo - 1 || y == 0 || y == vdo - 1) ? 24'hFFFFFF : 24'h000000;
    endcase
    return res;
  endfunction

  // Drive one cycle of inputs and queue what the outputs must show after the capturing edge
  task automatic cyc(input logic rst_n, input logic hs, input logic vs, input logic de,
                     input logic [23:0] pix);
    exp_t e;
    DRST_X    = rst_n;
    HSYNC_X_I = hs;
    VSYNC_X_I = vs;
    PREDE_I   = de;
    @(posedge DCLK);
    if (!rst_n) begin
      e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.rgb = 24'h0;
    end else begin
      e.hs = hs; e.vs = vs; e.de = de; e.rgb = de ? pix : 24'h0;
    end
    sb.push_back(e);
    #1;
  endtask

  // One line: 2 hsync, 2 back porch, w active (when active), 2 front porch
  task automatic do_line(input logic vs, input int w, input bit active, input int y,
                         input bit rst_first);
    for (int c = 0; c < w + 6; c++) begin
      logic        hs, de, rst_n;
      logic [23:0] pix;
      hs    = (c < 2) ? 1'b0 : 1'b1;
      de    = active && (c >= 4) && (c < 4 + w);
      rst_n = !(rst_first && c == 0);
      pix   = de ? model_pix(lat_psel, lat_resol, c - 4, y, frame_no) : 24'h0;
      cyc(rst_n, hs, vs, de, pix);
    end
  endtask

  // Frame: 2 vsync lines, 1 blank, h active, 1 blank. Optional PSEL/RESOL change and reset
  // at the start of a given active line.
  task automatic do_frame(input int w, input int h, input int ps, input int rs,
                          input int chg_line, input int chg_ps, input int chg_rs,
                          input int rst_line);
    int y0;
    PSEL      = 3'(ps);
    RESOL     = 2'(rs);
    frame_no  = (frame_no + 1) % 256;
    lat_psel  = ps;
    lat_resol = rs;
    do_line(1'b0, w, 1'b0, 0, 1'b0);
    do_line(1'b0, w, 1'b0, 0, 1'b0);
    do_line(1'b1, w, 1'b0, 0, 1'b0);
    y0 = 0;
    for (int l = 0; l < h; l++) begin
      if (l == chg_line) begin
        PSEL  = 3'(chg_ps);
        RESOL = 2'(chg_rs);
      end
      if (l == rst_line) begin
        lat_psel  = 0;
        lat_resol = 0;
        frame_no  = 0;
        y0        = l;
      end
      do_line(1'b1, w, 1'b1, l - y0, l == rst_line);
    end
    do_line(1'b1, w, 1'b0, 0, 1'b0);
  endtask

  // Monitor: the DUT presents an output every cycle
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge DCLK);
      #2;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        n_tests++;
        if ({DSP_HSYNC_X, DSP_VSYNC_X, DSP_DE} !== {mon_e.hs, mon_e.vs, mon_e.de}) begin
          n_fail++;
          $display("FAIL sync_de at %0t: got hs/vs/de=%b%b%b expected %b%b%b", $time,
                   DSP_HSYNC_X, DSP_VSYNC_X, DSP_DE, mon_e.hs, mon_e.vs, mon_e.de);
        end
        n_tests++;
        if ({DSP_R, DSP_G, DSP_B} !== mon_e.rgb) begin
          n_fail++;
          $display("FAIL rgb at %0t: got %h%h%h expected %h", $time, DSP_R, DSP_G, DSP_B,
                   mon_e.rgb);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL timeout: bench did not complete, got %0d pending expected 0", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    int w, h, ps, rs, cl;
    DRST_X    = 1'b0;
    RESOL     = 2'd0;
    PSEL      = 3'd0;
    HSYNC_X_I = 1'b1;
    VSYNC_X_I = 1'b1;
    PREDE_I   = 1'b0;

    // Reset held for 3 cycles while inputs toggle
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'(i), 1'(~i), 1'(i), 24'h0);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 24'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 24'h0);

    // Colour bars at 640 wide
    do_frame(640, 3, 0, 0, -1, 0, 0, -1);
    // Border at 1024 wide, then a tall narrow frame reaching line 767
    do_frame(1024, 3, 7, 2, -1, 0, 0, -1);
    do_frame(4, 770, 7, 2, -1, 0, 0, -1);
    // Scrolling checker over consecutive frames
    for (int i = 0; i < 3; i++) do_frame(70, 2, 3, i, -1, 0, 0, -1);
    // Ramp with PSEL/RESOL changed mid-frame; next frame picks up solid red
    do_frame(400, 4, 1, 0, 2, 4, 3, -1);
    do_frame(400, 2, 4, 3, -1, 0, 0, -1);
    // Reset in the middle of a frame, then resynchronise
    do_frame(90, 5, 2, 1, -1, 0, 0, 2);
    // Many tiny frames so the frame counter wraps 255 -> 0
    for (int i = 0; i < 262; i++) begin
      w  = $urandom_range(2, 20);
      ps = ($urandom_range(0, 1) == 0) ? 3 : $urandom_range(0, 7);
      do_frame(w, 2, ps, $urandom_range(0, 3), -1, 0, 0, -1);
    end
    // Random frames with random mid-frame select changes
    for (int i = 0; i < 8; i++) begin
      w  = $urandom_range(2, 120);
      h  = $urandom_range(1, 5);
      ps = $urandom_range(0, 7);
      rs = $urandom_range(0, 3);
      cl = $urandom_range(0, 5);
      do_frame(w, h, ps, rs, cl, $urandom_range(0, 7), $urandom_range(0, 3), -1);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 24'h0);

    @(posedge DCLK);
    #3;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
